// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes and FSM state type shared by the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam logic [1:0] MULDIV_MULTU = 2'b00;
  localparam logic [1:0] MULDIV_MULT  = 2'b01;
  localparam logic [1:0] MULDIV_DIVU  = 2'b10;
  localparam logic [1:0] MULDIV_DIV   = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} muldiv_state_t;
endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/result bundle between a pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  modport master (output start, op, src1, src2, flush, input busy, done, hi, lo, div_zero);
  modport slave (input start, op, src1, src2, flush, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring divide on {acc,mq}.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] mq_n
);
  logic [WIDTH:0] sum, rs;
  logic ge;
  assign sum = {1'b0, acc} + {1'b0, a};
  assign rs  = {acc, mq[WIDTH-1]};
  assign ge  = rs >= {1'b0, a};
  // divide shifts quotient bits into mq; multiply shifts product bits out of mq
  assign {acc_n, mq_n} = div ? {ge ? rs[WIDTH-1:0] - a : rs[WIDTH-1:0], mq[WIDTH-2:0], ge}
                             : {mq[0] ? sum : {1'b0, acc}, mq[WIDTH-1:1]};
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: fixed-latency iterative MULT/MULTU/DIV/DIVU producing HI/LO results.
// Signed MULT/DIV only when HILO_MULDIV_SIGNED_EN is defined; otherwise every op is unsigned.
module hilo_muldiv import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          rstn,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef HILO_MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  muldiv_state_t    state;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, dz, sgn, s1, s2, div_zero;
  logic [WIDTH-1:0] a, acc, mq, acc_n, mq_n, m1, m2, hi, lo, hi_f, lo_f;
  logic [2*WIDTH-1:0] prod;
  assign sgn  = SIGNED_EN && (bus.op == MULDIV_MULT || bus.op == MULDIV_DIV);
  assign s1   = sgn & bus.src1[WIDTH-1];
  assign s2   = sgn & bus.src2[WIDTH-1];
  assign m1   = s1 ? -bus.src1 : bus.src1;
  assign m2   = s2 ? -bus.src2 : bus.src2;
  // iterate on magnitudes; FIX restores signs, leaving divide-by-zero quotient as all ones
  assign prod = neg_q ? -{acc, mq} : {acc, mq};
  assign lo_f = is_div ? (neg_q ? -mq : mq) : prod[WIDTH-1:0];
  assign hi_f = is_div ? (neg_r ? -acc : acc) : prod[2*WIDTH-1:WIDTH];
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.div_zero = div_zero;
  muldiv_step #(.WIDTH(WIDTH)) step (.div(is_div), .a(a), .acc(acc), .mq(mq), .acc_n(acc_n), .mq_n(mq_n));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      a        <= '0;
      acc      <= '0;
      mq       <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (bus.flush && state != IDLE) state <= IDLE;
    else case (state)
      IDLE: if (bus.start && !bus.flush) begin
        state  <= RUN;
        cnt    <= '0;
        is_div <= bus.op inside {MULDIV_DIVU, MULDIV_DIV};
        dz     <= bus.src2 == '0;
        neg_q  <= (s1 ^ s2) && !(bus.op[1] && bus.src2 == '0);
        neg_r  <= s1;
        a      <= m2;
        acc    <= '0;
        mq     <= m1;
      end
      RUN: begin
        acc <= acc_n;
        mq  <= mq_n;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state <= FIX;
      end
      FIX: begin
        hi    <= hi_f;
        lo    <= lo_f;
        if (is_div) div_zero <= dz;
        state <= DONE;
      end
      DONE: state <= IDLE;
    endcase
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed and random checks of hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;
  import muldiv_pkg::*;
`ifdef HILO_MULDIV_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mh = '0, ml = '0;
  logic mdz = 1'b0;
  always #5 clk = ~clk;
  hilo_muldiv_if #(.WIDTH(32)) bus();
  hilo_muldiv #(.WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l, inout logic z);
    logic sg;
    longint sx, sy;
    logic [63:0] p;
    sg = o[0] & SG;
    sx = sg ? longint'($signed(x)) : longint'({32'b0, x});
    sy = sg ? longint'($signed(y)) : longint'({32'b0, y});
    if (!o[1]) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == 0) begin
      l = '1;
      h = x;
      z = 1'b1;
    end else begin
      l = 32'(sx / sy);
      h = 32'(sx % sy);
      z = 1'b0;
    end
  endfunction

  // call at a negedge: that cycle is cycle 0, the start is sampled at its closing edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int ign1, input int ign2, input int fl, input string tag);
    int dcyc, bad, last;
    logic [31:0] eh, el;
    logic ed;
    eh = mh; el = ml; ed = mdz;
    if (fl < 0) model(o, x, y, eh, el, ed);
    last = fl < 0 ? 33 : fl;
    bus.start = 1'b1; bus.op = o; bus.src1 = x; bus.src2 = y; bus.flush = 1'b0;
    dcyc = -1; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == ign1) || (c == ign2);
      bus.flush = c == fl;
      if (bus.start) begin bus.op = 2'($urandom); bus.src1 = $urandom; bus.src2 = $urandom; end
      if (bus.done && dcyc < 0) dcyc = c;
      if (c <= last && !bus.busy) bad++;
      if (c == dcyc) begin
        chk({tag, "_hi"}, bus.hi, eh);
        chk({tag, "_lo"}, bus.lo, el);
        chk({tag, "_dz"}, bus.div_zero, ed);
      end
      if (fl >= 0 && c == fl + 1) begin
        chk({tag, "_flush_busy"}, bus.busy, 0);
        chk({tag, "_flush_hi"}, bus.hi, mh);
        chk({tag, "_flush_lo"}, bus.lo, ml);
        break;
      end
      if (dcyc >= 0 && c == dcyc + 1) begin
        chk({tag, "_post_busy"}, bus.busy, 0);
        chk({tag, "_post_done"}, bus.done, 0);
        break;
      end
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    chk({tag, "_busy_window"}, bad, 0);
    chk({tag, "_done_cycle"}, dcyc, fl < 0 ? 34 : -1);
    mh = eh; ml = el; mdz = ed;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    logic [31:0] x, y;
    rstn = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.busy, bus.done, bus.hi, bus.lo, bus.div_zero}, 0);
    rstn = 1'b1;
    @(negedge clk);
    run_op(MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, "multu_max");
    chk("multu_max_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    run_op(MULDIV_MULT, 32'hFFFFFFFD, 32'h7, -1, -1, -1, "mult_neg");
    chk("mult_neg_const", {bus.hi, bus.lo}, SG ? 64'hFFFFFFFF_FFFFFFEB : 64'h00000006_FFFFFFEB);
    run_op(MULDIV_DIV, 32'hFFFFFFF9, 32'h2, -1, -1, -1, "div_neg");
    if (SG) chk("div_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, -1, "div_ovf");
    if (SG) chk("div_ovf_const", {bus.hi, bus.lo, bus.div_zero}, {64'h00000000_80000000, 1'b0});
    run_op(MULDIV_DIVU, 32'h64, 32'h0, -1, -1, -1, "divu_zero");
    chk("divu_zero_const", {bus.hi, bus.lo, bus.div_zero}, {64'h00000064_FFFFFFFF, 1'b1});
    run_op(MULDIV_MULTU, 32'h3, 32'h5, -1, -1, -1, "mul_keeps_dz");
    chk("mul_keeps_dz_const", bus.div_zero, 1);
    run_op(MULDIV_DIVU, 32'h7, 32'h2, -1, -1, -1, "divu_7_2");
    chk("divu_7_2_const", {bus.hi, bus.lo, bus.div_zero}, {64'h00000001_00000003, 1'b0});
    run_op(MULDIV_DIVU, 32'h12345678, 32'h9, -1, -1, 10, "flush10");
    run_op(MULDIV_MULTU, 32'h1234, 32'h5678, -1, -1, -1, "after_flush");
    run_op(MULDIV_DIVU, 32'h1000, 32'h7, 5, 33, -1, "ign_start");
    run_op(MULDIV_MULT, 32'hFFFF0000, 32'h10, 34, -1, -1, "start_in_done");
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MULDIV_MULTU; bus.src1 = 32'h2; bus.src2 = 32'h3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_wins", bus.busy, 0);
    for (int i = 0; i < 24; i++) begin
      x = pick();
      y = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      run_op(2'($urandom), x, y, -1, -1, -1, $sformatf("rnd%0d", i));
    end
    bus.start = 1'b1; bus.op = MULDIV_DIVU; bus.src1 = 32'hDEAD; bus.src2 = 32'h3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rstn = 1'b0;
    #1;
    chk("midop_reset_outs", {bus.busy, bus.done, bus.hi, bus.lo, bus.div_zero}, 0);
    @(negedge clk);
    rstn = 1'b1;
    mh = '0; ml = '0; mdz = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("no_done_after_reset", dn, 0);
    run_op(MULDIV_MULT, 32'h7FFFFFFF, 32'h80000000, -1, -1, -1, "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  operation request, sampled each cycle.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port src1  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port src2  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port flush  input  1  abort of any operation in flight.
REQ-009 SHALL have port busy  output  1  high when state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; hi/lo/div_zero are valid for the new result.
REQ-011 SHALL have port hi  output  WIDTH  product upper half, or remainder.
REQ-012 SHALL have port lo  output  WIDTH  product lower half, or quotient.
REQ-013 SHALL have port div_zero  output  1  last completed divide had src2 == 0.

Function
REQ-014 SHALL use the states IDLE, RUN, FIX and DONE.
REQ-015 SHALL accept start only in IDLE with flush low; accepted op/src1/src2 are captured, state goes to RUN, iteration counter is cleared.
REQ-016 SHALL ignore start while busy; captured operands stay unchanged.
REQ-017 SHALL execute one shift-add (multiply) or restoring-subtract (divide) step per RUN cycle, exactly WIDTH RUN cycles, then go to FIX.
REQ-018 SHALL apply signed result correction in FIX (1 cycle), then go to DONE; DONE lasts 1 cycle with done=1, then returns to IDLE.
REQ-019 SHALL use fixed latency: start sampled at edge ending cycle 0 -> done high in cycle WIDTH+2 (cycle 34 for WIDTH=32), independent of operand values.
REQ-020 SHALL update hi/lo/div_zero only when entering DONE; they hold until the next DONE.
REQ-021 SHALL produce for MULT/MULTU the full 2*WIDTH product in {hi,lo}.
REQ-022 SHALL produce for DIV a quotient truncated toward zero and a remainder carrying the sign of the dividend.
REQ-023 SHALL handle divisor zero with normal latency: lo = all ones, hi = src1, div_zero=1; any non-zero divide sets div_zero=0; multiplies leave div_zero unchanged.
REQ-024 SHALL handle DIV of most-negative / -1 as: lo = most-negative, hi = 0, no flag.
REQ-025 SHALL respond to flush in any non-IDLE state by returning to IDLE next cycle, with no done and hi/lo/div_zero unchanged; flush in DONE suppresses nothing already registered (done still pulses that cycle).
REQ-026 SHALL resolve start and flush in the same IDLE cycle as flush wins: the start is not accepted.
REQ-027 SHALL NOT accept a start issued in the DONE cycle; the earliest re-accept is the following IDLE cycle.

Reset
REQ-028 SHALL, on rstn low, set state IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter and operand registers cleared.
REQ-029 SHALL discard any operation in flight when reset is asserted mid-operation; after release the first accepted start behaves per REQ-019.

Configuration
REQ-030 SHALL support macro HILO_MULDIV_SIGNED_EN: when defined, MULT/DIV are signed per REQ-022/024.
REQ-031 SHALL, when HILO_MULDIV_SIGNED_EN is not defined, ignore op[0] and execute every operation unsigned; FIX is still traversed, so latency is identical.

Structure
REQ-032 SHALL take from shared package muldiv_pkg: op code constants (MULDIV_MULTU/MULT/DIVU/DIV) and the state enum type.
REQ-033 SHALL place one iteration step (shift-add / trial subtract, combinational) in sub-module muldiv_step; all registers stay in hilo_muldiv.

Verification
REQ-034 SHALL verify MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly in cycle 34, busy high cycles 1..33.
REQ-035 SHALL verify MULT 0xFFFFFFFD*0x00000007 (SIGNED_EN) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; without macro -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-036 SHALL verify DIV 0xFFFFFFF9/0x00000002 (SIGNED_EN) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL verify DIVU 0x00000064/0 -> lo=0xFFFFFFFF, hi=0x00000064, div_zero=1; next DIVU 7/2 -> lo=3, hi=1, div_zero=0.
REQ-038 SHALL verify a DIVU flushed in cycle 10 -> busy=0 in cycle 11, no done, hi/lo keep the prior result; a start in cycle 11 completes in cycle 45.
REQ-039 SHALL verify start pulses in cycles 5 and 33 of a running op are ignored; rstn low in cycle 12 zeroes all outputs, and no done follows.
